apb_bus_arbiter: RTL and testbench

//  Shares one APB3 master port among NREQ local requesters. Each requester

---
 rtl/apb_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter that shares one APB3 master port among NREQ requesters.
// It sequences SETUP/ACCESS, absorbs wait states and ends hung transfers with a watchdog.
module apb_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*DW-1:0]        req_wdata,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [DW-1:0]             rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_tmo,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [AW-1:0]             PADDR,
    output logic [DW-1:0]             PWDATA,
    input  logic [DW-1:0]             PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [WDW-1:0] wd;
    logic [IDW-1:0] win;
    logic           found;
    logic [IDW:0]   sum;
    logic           xfer_ok, xfer_tmo;
    logic [AW-1:0]  addr_arr  [NREQ];
    logic [DW-1:0]  wdata_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
        end
    end

    // Search starts at rr_ptr and wraps, so the last winner is checked last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDW-1:0];
            end
        end
    end

    // PREADY is checked before the watchdog so a late ready still completes normally.
    always_comb begin
        state_n  = state;
        xfer_ok  = 1'b0;
        xfer_tmo = 1'b0;
        case (state)
            IDLE:   if (found) state_n = SETUP;
            SETUP:  state_n = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    xfer_ok = 1'b1;
                    state_n = IDLE;
                end else if (wd == WD_LAST) begin
                    xfer_tmo = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            wd        <= '0;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            state     <= state_n;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
            if (state == IDLE && found) begin
                req_ready <= NREQ'(1) << win;
                rr_ptr    <= (win == LAST_ID) ? '0 : win + 1'b1;
                cur_id    <= win;
                PSEL      <= 1'b1;
                PENABLE   <= 1'b0;
                PWRITE    <= req_write[win];
                PADDR     <= addr_arr[win];
                PWDATA    <= req_write[win] ? wdata_arr[win] : '0;
            end
            if (state == SETUP)
                PENABLE <= 1'b1;
            if (state == ACCESS)
                wd <= wd + 1'b1;
            if (xfer_ok || xfer_tmo) begin
                PSEL      <= 1'b0;
                PENABLE   <= 1'b0;
                wd        <= '0;
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_err   <= xfer_tmo | PSLVERR;
                rsp_tmo   <= xfer_tmo;
                rsp_rdata <= (xfer_ok && !PWRITE) ? PRDATA : '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter: handshake timing, round-robin order,
// wait states, watchdog timeout, slave error and mid-transfer reset.
module tb_apb_bus_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NREQ-1:0]   req_valid, req_write, req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic              rsp_valid, rsp_err, rsp_tmo;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_rdata, PWDATA, PRDATA;
    logic [AW-1:0]     PADDR;
    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;
    int n_acc;

    apb_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", PADDR, 0);
        PRESET = 1'b0;
        tick();

        // Single write from requester 0, zero-wait slave
        req_valid = 4'b0001; req_write = 4'b0001;
        req_addr[0*AW +: AW] = 32'h10; req_wdata[0*DW +: DW] = 32'hA5A5; PREADY = 1'b1;
        tick();
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_psel", PSEL, 1);
        chk("t1_penable_setup", PENABLE, 0);
        chk("t1_paddr", PADDR, 32'h10);
        chk("t1_pwrite", PWRITE, 1);
        chk("t1_pwdata", PWDATA, 32'hA5A5);
        req_valid = '0;
        tick();
        chk("t1_penable", PENABLE, 1);
        chk("t1_rsp_early", rsp_valid, 0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        chk("t1_psel_off", PSEL, 0);

        // Round robin, all requesters valid; reset first to start at pointer 0
        PRESET = 1'b1; tick(); PRESET = 1'b0;
        req_write = '0; PRDATA = 32'h12345678;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 32'h100 + i;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_grant", req_ready, 4'(1) << exp_order[k]);
            chk("t2_paddr", PADDR, 32'h100 + exp_order[k]);
            chk("t2_pwdata_read", PWDATA, 0);
            tick();
            tick();
            chk("t2_rsp_valid", rsp_valid, 1);
            chk("t2_rsp_id", rsp_id, exp_order[k]);
            chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);
        end

        // Read with 3 wait states; PSLVERR asserted only while PREADY is low
        req_valid = 4'b0100; req_write = '0; req_addr[2*AW +: AW] = 32'h20;
        PREADY = 1'b0; PRDATA = 32'hDEADBEEF;
        tick();
        chk("t3_grant", req_ready, 4'b0100);
        chk("t3_paddr", PADDR, 32'h20);
        req_valid = '0; PSLVERR = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) begin PREADY = 1'b1; PSLVERR = 1'b0; end
            chk("t3_psel", PSEL, 1);
            chk("t3_penable", PENABLE, 1);
            chk("t3_paddr_hold", PADDR, 32'h20);
            chk("t3_no_rsp", rsp_valid, 0);
        end
        tick();
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_id", rsp_id, 2);
        chk("t3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t3_rsp_err", rsp_err, 0);

        // Watchdog: slave never ready, then requester 0 is granted next
        req_valid = 4'b1001; req_write = 4'b1001; PREADY = 1'b0;
        req_addr[3*AW +: AW] = 32'h30; req_addr[0*AW +: AW] = 32'h40;
        req_wdata[0*DW +: DW] = 32'h77;
        tick();
        chk("t4_grant", req_ready, 4'b1000);
        req_valid = 4'b0001;
        tick();
        n_acc = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) break;
            if (PSEL && PENABLE) n_acc++;
            tick();
        end
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_access_cycles", n_acc, 16);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_tmo", rsp_tmo, 1);
        chk("t4_rsp_id", rsp_id, 3);
        chk("t4_rsp_rdata", rsp_rdata, 0);

        // Slave error on a write completion
        PREADY = 1'b1; PSLVERR = 1'b1;
        tick();
        chk("t5_grant", req_ready, 4'b0001);
        chk("t5_paddr", PADDR, 32'h40);
        chk("t5_pwdata", PWDATA, 32'h77);
        req_valid = '0;
        tick();
        tick();
        chk("t5_rsp_valid", rsp_valid, 1);
        chk("t5_rsp_err", rsp_err, 1);
        chk("t5_rsp_tmo", rsp_tmo, 0);
        PSLVERR = 1'b0;

        // Reset during ACCESS aborts the transfer and clears the pointer
        req_valid = 4'b0010; PREADY = 1'b0;
        tick();
        chk("t6_grant", req_ready, 4'b0010);
        req_valid = '0;
        tick();
        chk("t6_in_access", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("t6_psel", PSEL, 0);
        chk("t6_penable", PENABLE, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        PREADY = 1'b1;
        tick();
        chk("t6_no_rsp", rsp_valid, 0);
        req_valid = 4'b1111;
        tick();
        chk("t6_rr_reset", req_ready, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
